dmem_lsu: RTL and testbench

- Load/store initiator between the CPU memory stage and the word-indexed data memory (dmem).
- Accepts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests and converts them to word accesses.
- Performs read-modify-write for sub-word stores, because dmem has no byte enables.
- Aligns and sign/zero-extends load data, and flags misaligned or illegal requests.

---
 rtl/dmem_lsu_if.sv | 33 +++
 rtl/dmem_lsu.sv | 150 +++++++++++++++
 tb/tb_dmem_lsu.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_lsu_if.sv
// Request/response and data-memory signals of the load/store unit.
// The LSU connects through slave; the CPU/dmem side connects through master.
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_load;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        is_load;
  logic        is_store;
  logic [31:0] mem_addr;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic [31:0] stat_loads;
  logic [31:0] stat_stores;

  modport slave (
    input  req_valid, req_is_load, req_is_store, req_funct3, req_addr, req_wdata, load_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, is_load, is_store, mem_addr, store_data,
           stat_loads, stat_stores
  );

  modport master (
    output req_valid, req_is_load, req_is_store, req_funct3, req_addr, req_wdata, load_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, is_load, is_store, mem_addr, store_data,
           stat_loads, stat_stores
  );
endinterface

// File: rtl/dmem_lsu.sv
// Byte-addressed load/store unit in front of a word-only dmem; sub-word stores use read-modify-write.
// Define LSU_STATS_EN to enable the saturating stat_loads/stat_stores counters.
module dmem_lsu #(
  parameter int ADDR_W = 15
) (
  input logic       clk,
  input logic       rst,
  dmem_lsu_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD_WAIT, RMW_WRITE} state_t;

  state_t      state;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;
  logic [1:0]  addr_lo_p1;
  logic [2:0]  funct3_p1;
  logic [15:0] wdata_p1;
  logic [31:0] mem_addr_q;
  logic [31:0] store_data_q;
  logic [31:0] mem_addr_c;
  logic [31:0] store_data_c;
  logic        accept, f3_ok, misaligned, req_err;
  logic        go_load, go_sw, go_rmw;
  logic        unused_addr_hi;

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lo,
                                              input logic [2:0] f3);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[{lo, 3'b000} +: 8];
    h = word[{lo[1], 4'b0000} +: 16];
    case (f3)
      3'd0:    return 32'(b);
      3'd1:    return 32'(h);
      3'd4:    return {24'd0, b};
      3'd5:    return {16'd0, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [1:0] lo,
                                              input logic [2:0] f3, input logic [15:0] wd);
    logic [31:0] r;
    r = word;
    if (f3[0]) r[{lo[1], 4'b0000} +: 16] = wd;
    else       r[{lo, 3'b000} +: 8]      = wd[7:0];
    return r;
  endfunction

  // Request decode: legality, alignment and which dmem access to launch
  assign bus.req_ready  = (state == IDLE);
  assign accept         = !rst && bus.req_valid && bus.req_ready &&
                          (bus.req_is_load || bus.req_is_store);
  assign f3_ok          = bus.req_is_store ? (bus.req_funct3 <= 3'd2)
                                           : (bus.req_funct3 <= 3'd5 && bus.req_funct3[1:0] != 2'd3);
  assign misaligned     = (bus.req_funct3[1:0] == 2'd1 && bus.req_addr[0]) ||
                          (bus.req_funct3[1:0] == 2'd2 && bus.req_addr[1:0] != 2'd0);
  assign req_err        = accept && ((bus.req_is_load && bus.req_is_store) || !f3_ok || misaligned);
  assign go_load        = accept && !req_err && bus.req_is_load;
  assign go_sw          = accept && !req_err && bus.req_is_store && bus.req_funct3 == 3'd2;
  assign go_rmw         = accept && !req_err && bus.req_is_store && bus.req_funct3 != 3'd2;
  assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

  assign bus.is_load    = go_load || go_rmw;
  assign bus.is_store   = go_sw || (!rst && state == RMW_WRITE);
  assign bus.mem_addr   = mem_addr_c;
  assign bus.store_data = store_data_c;

  always_comb begin
    mem_addr_c   = mem_addr_q;
    store_data_c = store_data_q;
    if (go_load || go_rmw || go_sw) mem_addr_c = 32'(bus.req_addr[ADDR_W+1:2]);
    if (go_sw) store_data_c = bus.req_wdata;
    else if (!rst && state == RMW_WRITE)
      store_data_c = merge_store(bus.load_data, addr_lo_p1, funct3_p1, wdata_p1);
  end

  // p1: request fields and last driven dmem address/data
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_lo_p1 <= bus.req_addr[1:0];
      funct3_p1  <= bus.req_funct3;
      wdata_p1   <= bus.req_wdata[15:0];
    end
    if (bus.is_load || bus.is_store) mem_addr_q <= mem_addr_c;
    if (bus.is_store) store_data_q <= store_data_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      case (state)
        IDLE: begin
          rsp_valid_q <= go_sw || req_err;
          rsp_err_q   <= req_err;
          if (go_load)     state <= LOAD_WAIT;
          else if (go_rmw) state <= RMW_WRITE;
        end
        LOAD_WAIT: begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= load_extend(bus.load_data, addr_lo_p1, funct3_p1);
          state       <= IDLE;
        end
        RMW_WRITE: begin
          rsp_valid_q <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

`ifdef LSU_STATS_EN
  logic [31:0] stat_loads_q;
  logic [31:0] stat_stores_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Counted on the edge that registers a successful response
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_loads_q  <= '0;
      stat_stores_q <= '0;
    end else begin
      if (state == LOAD_WAIT) stat_loads_q <= sat_inc(stat_loads_q);
      if (go_sw || state == RMW_WRITE) stat_stores_q <= sat_inc(stat_stores_q);
    end
  end

  assign bus.stat_loads  = stat_loads_q;
  assign bus.stat_stores = stat_stores_q;
`else
  assign bus.stat_loads  = '0;
  assign bus.stat_stores = '0;
`endif
endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: a behavioural byte-memory model predicts responses and dmem traffic.
module tb_dmem_lsu;
  localparam int ADDR_W    = 15;
  localparam int MEM_WORDS = 1 << ADDR_W;

  typedef struct { int cyc; logic [31:0] rdata; logic err; } rsp_t;
  typedef struct { int cyc; logic [31:0] addr; logic [31:0] data; } acc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_clear = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   exp_loads = 0;
  int   exp_stores = 0;

  rsp_t rsp_q[$];
  acc_t ld_q[$];
  acc_t st_q[$];
  logic [31:0] dmem    [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];

  dmem_lsu_if bus();
  dmem_lsu #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Word memory behind the LSU: registered read, write at the clock edge
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < MEM_WORDS; i++) dmem[i] <= '0;
    end else begin
      if (bus.is_store) dmem[bus.mem_addr[ADDR_W-1:0]] <= bus.store_data;
      if (bus.is_load)  bus.load_data <= dmem[bus.mem_addr[ADDR_W-1:0]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_rsp(input int c, input logic [31:0] d, input logic e);
    rsp_t r;
    r.cyc = c; r.rdata = d; r.err = e;
    rsp_q.push_back(r);
  endtask

  task automatic push_acc(input bit is_st, input int c, input int widx, input logic [31:0] d);
    acc_t a;
    a.cyc = c; a.addr = 32'(widx); a.data = d;
    if (is_st) st_q.push_back(a);
    else       ld_q.push_back(a);
  endtask

  // Monitor: every strobe and response must match the head of its queue
  initial begin
    rsp_t r;
    acc_t a;
    forever begin
      @(negedge clk);
      #1;
      if (bus.is_load === 1'b1) begin
        chk("ld_expected", 32'(ld_q.size() != 0), 32'd1);
        if (ld_q.size() != 0) begin
          a = ld_q.pop_front();
          chk("ld_addr", bus.mem_addr, a.addr);
          chk("ld_cycle", 32'(cyc), 32'(a.cyc));
        end
      end
      if (bus.is_store === 1'b1) begin
        chk("st_expected", 32'(st_q.size() != 0), 32'd1);
        if (st_q.size() != 0) begin
          a = st_q.pop_front();
          chk("st_addr", bus.mem_addr, a.addr);
          chk("st_data", bus.store_data, a.data);
          chk("st_cycle", 32'(cyc), 32'(a.cyc));
        end
      end
      if (bus.rsp_valid === 1'b1) begin
        chk("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
        if (rsp_q.size() != 0) begin
          r = rsp_q.pop_front();
          chk("rsp_cycle", 32'(cyc), 32'(r.cyc));
          chk("rsp_rdata", bus.rsp_rdata, r.rdata);
          chk("rsp_err", 32'(bus.rsp_err), 32'(r.err));
        end
      end
    end
  end

  // Issue one request (called just after a rising edge) and predict its effects
  task automatic send(input logic ld, input logic st, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd);
    int t, widx, off, size;
    logic legal, err;
    logic [31:0] w, v, mask, nw;
    bus.req_valid = 1'b1; bus.req_is_load = ld; bus.req_is_store = st;
    bus.req_funct3 = f3; bus.req_addr = addr; bus.req_wdata = wd;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (bus.req_ready !== 1'b1 && t < 20);
    if (bus.req_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL req_ready_timeout: got 0, expected 1 within 20 cycles");
    end else if (ld || st) begin
      t    = cyc;
      widx = int'((addr / 32'd4) % 32'(MEM_WORDS));
      off  = int'(addr % 32'd4);
      size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
      err   = (ld && st) || !legal || (off % size != 0);
      if (err) begin
        push_rsp(t + 1, 32'd0, 1'b1);
      end else if (ld) begin
        w = ref_mem[widx] >> (8 * off);
        if (size == 1) begin
          v = w & 32'hFF;
          if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2) begin
          v = w & 32'hFFFF;
          if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        end else begin
          v = w;
        end
        push_acc(1'b0, t, widx, 32'd0);
        push_rsp(t + 2, v, 1'b0);
        exp_loads++;
      end else if (size == 4) begin
        ref_mem[widx] = wd;
        push_acc(1'b1, t, widx, wd);
        push_rsp(t + 1, 32'd0, 1'b0);
        exp_stores++;
      end else begin
        mask = ((size == 1) ? 32'hFF : 32'hFFFF) << (8 * off);
        nw   = (ref_mem[widx] & ~mask) | ((wd << (8 * off)) & mask);
        ref_mem[widx] = nw;
        push_acc(1'b0, t, widx, 32'd0);
        push_acc(1'b1, t + 1, widx, nw);
        push_rsp(t + 2, 32'd0, 1'b0);
        exp_stores++;
      end
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((rsp_q.size() + ld_q.size() + st_q.size()) != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_stats(input string tag);
    @(negedge clk);
`ifdef LSU_STATS_EN
    chk({tag, "_stat_loads"}, bus.stat_loads, 32'(exp_loads));
    chk({tag, "_stat_stores"}, bus.stat_stores, 32'(exp_stores));
`else
    chk({tag, "_stat_loads"}, bus.stat_loads, 32'd0);
    chk({tag, "_stat_stores"}, bus.stat_stores, 32'd0);
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ld, st;
    logic [2:0] f3;
    logic [31:0] addr;
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = '0;
    // A request held during reset must not strobe dmem
    bus.req_valid = 1'b1; bus.req_is_load = 1'b1; bus.req_is_store = 1'b0;
    bus.req_funct3 = 3'd2; bus.req_addr = 32'h40; bus.req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_is_load", 32'(bus.is_load), 32'd0);
    chk("rst_is_store", 32'(bus.is_store), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; mem_clear = 1'b0; bus.req_valid = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("reset_stat_loads", bus.stat_loads, 32'd0);
    @(posedge clk);
    #1;

    // Lane selection and extension on word 0x10
    send(1'b0, 1'b1, 3'd2, 32'h40, 32'h8081_7F01);
    send(1'b1, 1'b0, 3'd0, 32'h41, 32'h0);
    send(1'b1, 1'b0, 3'd0, 32'h43, 32'h0);
    send(1'b1, 1'b0, 3'd5, 32'h42, 32'h0);
    send(1'b1, 1'b0, 3'd1, 32'h42, 32'h0);
    // Read-modify-write byte store, then readback
    send(1'b0, 1'b1, 3'd2, 32'h40, 32'h1122_3344);
    send(1'b0, 1'b1, 3'd0, 32'h42, 32'h0000_00AB);
    send(1'b1, 1'b0, 3'd2, 32'h40, 32'h0);
    // Store immediately followed by a load of the same word
    send(1'b0, 1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF);
    send(1'b1, 1'b0, 3'd2, 32'h100, 32'h0);
    // Errors, ignored request, address wrap
    send(1'b1, 1'b0, 3'd2, 32'h102, 32'h0);
    send(1'b0, 1'b1, 3'd1, 32'h101, 32'h1234);
    send(1'b1, 1'b0, 3'd3, 32'h40, 32'h0);
    send(1'b1, 1'b1, 3'd2, 32'h40, 32'h0);
    send(1'b0, 1'b1, 3'd4, 32'h40, 32'h0);
    send(1'b0, 1'b0, 3'd2, 32'h40, 32'h0);
    send(1'b1, 1'b0, 3'd2, 32'hFFFE_0100, 32'h0);
    send(1'b0, 1'b1, 3'd1, 32'h8000_0102, 32'hCAFE_5A5A);
    send(1'b1, 1'b0, 3'd2, 32'h100, 32'h0);
    wait_idle();
    chk_stats("directed");

    // Abandon a byte store with reset during its write cycle
    bus.req_valid = 1'b1; bus.req_is_load = 1'b0; bus.req_is_store = 1'b1;
    bus.req_funct3 = 3'd0; bus.req_addr = 32'h41; bus.req_wdata = 32'h55;
    @(negedge clk);
    push_acc(1'b0, cyc, 16, 32'd0);
    chk("abort_accept_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_is_store", 32'(bus.is_store), 32'd0);
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_loads = 0;
    exp_stores = 0;
    @(negedge clk);
    chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
    chk("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    send(1'b1, 1'b0, 3'd2, 32'h40, 32'h0);

    // Randomized traffic over a small window of words, with wrapped upper address bits
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 19))
        0:       begin ld = 1'b1; st = 1'b1; end
        1:       begin ld = 1'b0; st = 1'b0; end
        default: begin ld = 1'($urandom_range(0, 1)); st = !ld; end
      endcase
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f3 = ld ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 2));
      addr = ($urandom & 32'hFFFE_0000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      send(ld, st, f3, addr, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
    wait_idle();
    chk("final_rsp_q_empty", 32'(rsp_q.size()), 32'd0);
    chk("final_ld_q_empty", 32'(ld_q.size()), 32'd0);
    chk("final_st_q_empty", 32'(st_q.size()), 32'd0);
    chk_stats("final");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
